// File: rtl/rggen_bit_field_access_initiator_if.sv
// Host-side request/response handshake of the bit-field access initiator.
// The host drives the master modport; the initiator sits on the slave modport.
interface rggen_bit_field_access_initiator_if #(
  parameter int WIDTH = 32
);

  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [WIDTH-1:0] req_mask;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_error;

  modport master (
    output req_valid,
    output req_write,
    output req_mask,
    output req_data,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_error
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_mask,
    input  req_data,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_error
  );

endinterface

// File: rtl/rggen_bit_field_access_initiator.sv
// Initiator side of the bit-field access protocol. Turns one host request
// into a single-cycle bit-field access (valid/read_mask/write_mask/write_data)
// and returns the captured read data and an error flag for accesses the
// field does not support. One transaction is outstanding at a time:
// IDLE -> ACCESS -> RESPONSE -> IDLE, or IDLE -> RESPONSE when rejected.
module rggen_bit_field_access_initiator #(
  parameter int WIDTH    = 32,
  parameter bit READABLE = 1'b1,
  parameter bit WRITABLE = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  rggen_bit_field_access_initiator_if.slave host_if,
  output logic                 o_bf_valid,
  output logic [WIDTH-1:0]     o_bf_read_mask,
  output logic [WIDTH-1:0]     o_bf_write_mask,
  output logic [WIDTH-1:0]     o_bf_write_data,
  input  logic [WIDTH-1:0]     i_bf_read_data
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    RESPONSE = 2'd2
  } state_e;

  state_e           state;
  state_e           state_next;

  logic             req_legal;
  logic             write_q;
  logic             bf_valid_q;
  logic [WIDTH-1:0] bf_read_mask_q;
  logic [WIDTH-1:0] bf_write_mask_q;
  logic [WIDTH-1:0] bf_write_data_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_error_q;

  // A request is legal when the field supports the requested direction.
  assign req_legal = host_if.req_write ? WRITABLE : READABLE;

  // State register; async reset drops any transaction in flight.
  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  // NOTE: state_next is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (host_if.req_valid) begin
          state_next = req_legal ? ACCESS : RESPONSE;
        end
      end
      ACCESS: begin
        state_next = RESPONSE;
      end
      RESPONSE: begin
        if (host_if.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch, registered bit-field strobes and response capture.
  // The o_bf_* registers are loaded on acceptance so they are high for
  // exactly the ACCESS cycle and cleared on the edge that leaves it.
  // NOTE: every flop here is cleared by the async reset so that o_bf_valid
  // drops immediately and no stale response survives a mid-operation reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      write_q         <= 1'b0;
      bf_valid_q      <= 1'b0;
      bf_read_mask_q  <= '0;
      bf_write_mask_q <= '0;
      bf_write_data_q <= '0;
      rsp_data_q      <= '0;
      rsp_error_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (host_if.req_valid) begin
            write_q     <= host_if.req_write;
            rsp_data_q  <= '0;
            rsp_error_q <= !req_legal;
            if (req_legal) begin
              bf_valid_q      <= 1'b1;
              bf_read_mask_q  <= host_if.req_write ? '0 : '1;
              bf_write_mask_q <= host_if.req_write ? host_if.req_mask : '0;
              bf_write_data_q <= host_if.req_data;
            end
          end
        end
        ACCESS: begin
          bf_valid_q      <= 1'b0;
          bf_read_mask_q  <= '0;
          bf_write_mask_q <= '0;
          bf_write_data_q <= '0;
          // Sampled on the access edge itself, so read-clear fields report
          // the value they held before clearing.
          if (!write_q) begin
            rsp_data_q <= i_bf_read_data;
          end
        end
        RESPONSE: begin
          if (host_if.rsp_ready) begin
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
          end
        end
        default: begin
          bf_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign host_if.req_ready = (state == IDLE);
  assign host_if.rsp_valid = (state == RESPONSE);
  assign host_if.rsp_data  = rsp_data_q;
  assign host_if.rsp_error = rsp_error_q;

  assign o_bf_valid      = bf_valid_q;
  assign o_bf_read_mask  = bf_read_mask_q;
  assign o_bf_write_mask = bf_write_mask_q;
  assign o_bf_write_data = bf_write_data_q;

endmodule

// File: tb/tb_rggen_bit_field_access_initiator.sv
// Testbench for rggen_bit_field_access_initiator. A write-1-to-set /
// read-to-clear 8-bit field model sits behind the main instance; a second
// instance with READABLE=0, WRITABLE=0 covers rejected accesses.
module tb_rggen_bit_field_access_initiator;

  localparam int W = 8;

  typedef struct {
    logic         write;
    logic [W-1:0] mask;
    logic [W-1:0] data;
    logic [W-1:0] exp_rdata;
    logic [W-1:0] exp_field;
  } vec_t;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_errors;

  // Main instance: fully accessible field.
  rggen_bit_field_access_initiator_if #(.WIDTH(W)) bus ();
  logic         bf_valid;
  logic [W-1:0] bf_read_mask;
  logic [W-1:0] bf_write_mask;
  logic [W-1:0] bf_write_data;
  logic [W-1:0] field;

  rggen_bit_field_access_initiator #(
    .WIDTH(W), .READABLE(1'b1), .WRITABLE(1'b1)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .host_if         (bus.slave),
    .o_bf_valid      (bf_valid),
    .o_bf_read_mask  (bf_read_mask),
    .o_bf_write_mask (bf_write_mask),
    .o_bf_write_data (bf_write_data),
    .i_bf_read_data  (field)
  );

  // Error instance: neither readable nor writable.
  rggen_bit_field_access_initiator_if #(.WIDTH(W)) bus_e ();
  logic         e_bf_valid;
  logic [W-1:0] e_bf_read_mask;
  logic [W-1:0] e_bf_write_mask;
  logic [W-1:0] e_bf_write_data;
  logic [W-1:0] field_e;
  logic         e_bf_seen;

  rggen_bit_field_access_initiator #(
    .WIDTH(W), .READABLE(1'b0), .WRITABLE(1'b0)
  ) dut_e (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .host_if         (bus_e.slave),
    .o_bf_valid      (e_bf_valid),
    .o_bf_read_mask  (e_bf_read_mask),
    .o_bf_write_mask (e_bf_write_mask),
    .o_bf_write_data (e_bf_write_data),
    .i_bf_read_data  (field_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field model: write 1 sets the bit, a read clears every read-masked bit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field <= 8'h00;
    end else if (bf_valid) begin
      field <= (field & ~bf_read_mask) | (bf_write_mask & bf_write_data);
    end
  end

  // Same model for the error instance, plus a sticky strobe detector.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field_e   <= 8'h3C;
      e_bf_seen <= 1'b0;
    end else if (e_bf_valid) begin
      field_e   <= (field_e & ~e_bf_read_mask) | (e_bf_write_mask & e_bf_write_data);
      e_bf_seen <= 1'b1;
    end
  end

  // Watchdog: the stimulus has fixed latency, this only catches a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One legal transaction on the main instance with rsp_ready held high.
  // After acceptance the request inputs are scrambled to show they are ignored.
  task automatic run_txn(input string p, input vec_t v);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = v.write;
    bus.req_mask  = v.mask;
    bus.req_data  = v.data;
    check({p, " req_ready"}, bus.req_ready, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = ~v.write;
    bus.req_mask  = ~v.mask;
    bus.req_data  = ~v.data;
    @(negedge clk);
    check({p, " N+1 bf_valid"}, bf_valid, 1);
    check({p, " N+1 read_mask"}, bf_read_mask, v.write ? 8'h00 : 8'hFF);
    check({p, " N+1 write_mask"}, bf_write_mask, v.write ? v.mask : 8'h00);
    check({p, " N+1 write_data"}, bf_write_data, v.data);
    check({p, " N+1 rsp_valid"}, bus.rsp_valid, 0);
    check({p, " N+1 req_ready"}, bus.req_ready, 0);
    @(negedge clk);
    check({p, " N+2 rsp_valid"}, bus.rsp_valid, 1);
    check({p, " N+2 rsp_data"}, bus.rsp_data, v.exp_rdata);
    check({p, " N+2 rsp_error"}, bus.rsp_error, 0);
    check({p, " N+2 bf_valid"}, bf_valid, 0);
    check({p, " N+2 bf_write_mask"}, bf_write_mask, 0);
    check({p, " field"}, field, v.exp_field);
    @(negedge clk);
    check({p, " done rsp_valid"}, bus.rsp_valid, 0);
    check({p, " done req_ready"}, bus.req_ready, 1);
  endtask

  // One request on the error instance; it must answer at N+1 with error.
  task automatic run_err(input string p, input logic wr, input logic [W-1:0] data);
    @(negedge clk);
    bus_e.req_valid = 1'b1;
    bus_e.req_write = wr;
    bus_e.req_mask  = 8'hFF;
    bus_e.req_data  = data;
    check({p, " req_ready"}, bus_e.req_ready, 1);
    @(posedge clk);
    #1;
    bus_e.req_valid = 1'b0;
    @(negedge clk);
    check({p, " N+1 rsp_valid"}, bus_e.rsp_valid, 1);
    check({p, " N+1 rsp_error"}, bus_e.rsp_error, 1);
    check({p, " N+1 rsp_data"}, bus_e.rsp_data, 0);
    check({p, " N+1 bf_valid"}, e_bf_valid, 0);
    @(negedge clk);
    check({p, " done rsp_valid"}, bus_e.rsp_valid, 0);
    check({p, " done req_ready"}, bus_e.req_ready, 1);
    check({p, " field unchanged"}, field_e, 8'h3C);
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;

    n_checks = 0;
    n_errors = 0;

    //          write  mask   data   rdata  field
    vecs[0] = '{1'b1, 8'hFF, 8'h0F, 8'h00, 8'h0F};  // write sets low nibble
    vecs[1] = '{1'b0, 8'h33, 8'h5A, 8'h0F, 8'h00};  // read returns pre-clear value
    vecs[2] = '{1'b0, 8'h00, 8'hC3, 8'h00, 8'h00};  // second read sees cleared field
    vecs[3] = '{1'b1, 8'h0F, 8'hA5, 8'h00, 8'h05};  // mask limits set bits to 0,2
    vecs[4] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'h05};  // writing zeros has no effect
    vecs[5] = '{1'b1, 8'h00, 8'hF0, 8'h00, 8'h05};  // zero mask still strobes, no error
    vecs[6] = '{1'b0, 8'hFF, 8'h11, 8'h05, 8'h00};
    vecs[7] = '{1'b1, 8'hFF, 8'h81, 8'h00, 8'h81};

    rst_n           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_mask    = '0;
    bus.req_data    = '0;
    bus.rsp_ready   = 1'b1;
    bus_e.req_valid = 1'b0;
    bus_e.req_write = 1'b0;
    bus_e.req_mask  = '0;
    bus_e.req_data  = '0;
    bus_e.rsp_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset req_ready", bus.req_ready, 1);
    check("reset rsp_valid", bus.rsp_valid, 0);
    check("reset rsp_data", bus.rsp_data, 0);
    check("reset rsp_error", bus.rsp_error, 0);
    check("reset bf_valid", bf_valid, 0);
    check("reset bf_read_mask", bf_read_mask, 0);
    check("reset err req_ready", bus_e.req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle bf_valid", bf_valid, 0);

    // Table-driven legal accesses.
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i]);
    end

    // Response back-pressure: read stalled for 5 cycles with a new request
    // already pending; the pending request is accepted right after handshake.
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_mask  = 8'h00;
    bus.req_data  = 8'h00;
    @(posedge clk);
    #1;
    bus.req_write = 1'b1;
    bus.req_mask  = 8'hFF;
    bus.req_data  = 8'h22;
    @(negedge clk);
    check("stall N+1 bf_valid", bf_valid, 1);
    check("stall N+1 read_mask", bf_read_mask, 8'hFF);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall c%0d rsp_valid", c), bus.rsp_valid, 1);
      check($sformatf("stall c%0d rsp_data", c), bus.rsp_data, 8'h81);
      check($sformatf("stall c%0d rsp_error", c), bus.rsp_error, 0);
      check($sformatf("stall c%0d req_ready", c), bus.req_ready, 0);
      check($sformatf("stall c%0d bf_valid", c), bf_valid, 0);
    end
    check("stall field cleared", field, 8'h00);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("post-stall rsp_valid", bus.rsp_valid, 0);
    check("post-stall req_ready", bus.req_ready, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("pending bf_valid", bf_valid, 1);
    check("pending write_mask", bf_write_mask, 8'hFF);
    check("pending write_data", bf_write_data, 8'h22);
    @(negedge clk);
    check("pending rsp_valid", bus.rsp_valid, 1);
    check("pending rsp_data", bus.rsp_data, 8'h00);
    check("pending field", field, 8'h22);
    @(negedge clk);
    check("pending done req_ready", bus.req_ready, 1);

    // Rejected accesses on the non-accessible instance.
    run_err("err read", 1'b0, 8'h00);
    run_err("err write", 1'b1, 8'hFF);
    check("err bf_valid never seen", e_bf_seen, 0);

    // Reset asserted during ACCESS.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_mask  = 8'h00;
    bus.req_data  = 8'h77;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst pre bf_valid", bf_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst async bf_valid", bf_valid, 0);
    check("rst async read_mask", bf_read_mask, 0);
    check("rst async write_data", bf_write_data, 0);
    check("rst async rsp_valid", bus.rsp_valid, 0);
    check("rst async rsp_data", bus.rsp_data, 0);
    check("rst async rsp_error", bus.rsp_error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post-rst c%0d rsp_valid", c), bus.rsp_valid, 0);
      check($sformatf("post-rst c%0d req_ready", c), bus.req_ready, 1);
      check($sformatf("post-rst c%0d bf_valid", c), bf_valid, 0);
    end
    v = '{1'b1, 8'hFF, 8'h0F, 8'h00, 8'h0F};
    run_txn("post-rst write", v);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
